dec_unpack: RTL

- Parametrised multi-channel ADPCM code-word unpacker at the front of the decoder path.
- Receives a TDM serial highway of NCH 8-bit time slots per frame.
- Extracts the 2/3/4/5-bit ADPCM code from each enabled slot according to the selected rate.
- Buffers {channel, code} pairs in a small FIFO and hands them to the per-channel decode engine over a valid/ready interface.

---
 rtl/dec_unpack.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dec_unpack.sv
// dec_unpack: TDM serial highway receiver that slices the 2..5-bit ADPCM code
// out of each enabled 8-bit time slot and queues {channel, code} pairs for
// the per-channel decode engine.
//
// Output handshake: code_vld is high whenever the FIFO head is occupied; an
// entry is consumed on every clk edge where code_vld & code_rdy; code and
// code_ch stay constant while code_vld & !code_rdy; code_vld never depends
// combinationally on code_rdy.
module dec_unpack #(
   parameter int NCH        = 4,
   parameter int CH_W       = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            scan_in0,
   input  logic            scan_en,
   output logic            scan_out0,
   input  logic            bclk_en,
   input  logic            fs,
   input  logic            sdi,
   input  logic [1:0]      rate,
   input  logic [NCH-1:0]  ch_en,
   output logic [4:0]      code,
   output logic [CH_W-1:0] code_ch,
   output logic            code_vld,
   input  logic            code_rdy,
   output logic            ovf,
   input  logic            ovf_clr,
   output logic            frm_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = CH_W + 5;
   localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NCH - 1);

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

   state_t          state, state_nxt;
   logic [2:0]      bit_cnt, bit_cnt_nxt;
   logic [CH_W-1:0] slot, slot_nxt;
   logic [7:0]      shift, shift_nxt;
   logic [1:0]      rate_q, rate_nxt;
   logic            frm_err_nxt;
   logic            push;
   logic [7:0]      rx_byte;
   logic [4:0]      code_new;

   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, pop, push_ok, drop;
   logic [EW-1:0]   head;

   // Scan chain is stitched after synthesis; the RTL only ties off the output.
   logic unused_ok;
   assign unused_ok = &{1'b0, scan_in0, scan_en, shift[7]};
   assign scan_out0 = 1'b0;

   // The byte as it stands once the current bit is shifted in (valid on bit 7).
   assign rx_byte = {shift[6:0], sdi};

   // Take the top rate_q+2 bits of the slot byte, right-justified.
   always_comb begin
      code_new = 5'd0;
      case (rate_q)
         2'd0:    code_new = {3'b000, rx_byte[7:6]};
         2'd1:    code_new = {2'b00,  rx_byte[7:5]};
         2'd2:    code_new = {1'b0,   rx_byte[7:4]};
         default: code_new = rx_byte[7:3];
      endcase
   end

   // Receiver next-state: frame hunt, bit/slot counting and code push request.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      slot_nxt    = slot;
      shift_nxt   = shift;
      rate_nxt    = rate_q;
      push        = 1'b0;
      frm_err_nxt = 1'b0;
      if (bclk_en) begin
         if (fs) begin
            // fs always (re)starts a frame; seen while running it aborts the
            // partial slot and is flagged.
            frm_err_nxt = (state == RUN);
            state_nxt   = RUN;
            bit_cnt_nxt = 3'd1;
            slot_nxt    = '0;
            shift_nxt   = {7'b0000000, sdi};
            rate_nxt    = rate;
         end else if (state == RUN) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               push = ch_en[slot];
               if (slot == LAST_SLOT) begin
                  // Trailing bits up to the next fs are dropped in HUNT.
                  state_nxt = HUNT;
                  slot_nxt  = '0;
               end else begin
                  slot_nxt = slot + 1'b1;
               end
            end
         end
      end
   end

   // Receiver state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HUNT;
         bit_cnt <= 3'd0;
         slot    <= '0;
         shift   <= 8'd0;
         rate_q  <= 2'd0;
         frm_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         slot    <= slot_nxt;
         shift   <= shift_nxt;
         rate_q  <= rate_nxt;
         frm_err <= frm_err_nxt;
      end
   end

   // FIFO status; a push into a full FIFO is only taken if the head leaves
   // in the same cycle.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = code_vld & code_rdy;
   assign push_ok = push & (~full | pop);
   assign drop    = push & full & ~pop;

   // FIFO storage; contents are don't-care until the pointer says valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= {slot, code_new};
      end
   end

   // FIFO pointers and sticky overflow flag (a new drop beats a clear).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   // Head presentation; zeroed when empty so outputs read 0 out of reset.
   assign code_vld = ~empty;
   assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign code_ch  = head[EW-1:5];
   assign code     = head[4:0];

endmodule
